camera_frame_parser: RTL and testbench

CAMERA_FRAME_PARSER -- requirements
Module: camera_frame_parser

---
 rtl/camera_pkg.sv | 19 +
 rtl/ascii_dec_acc.sv | 77 +++++++
 rtl/camera_frame_parser.sv | 149 ++++++++++++++
 tb/tb_camera_frame_parser.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/camera_pkg.sv
// Shared types and default framing characters for the camera frame parser.
package camera_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SIGN,
    DIGITS
  } state_e;

  localparam logic [7:0] DEF_START_CHAR = 8'h3C;  // '<'
  localparam logic [7:0] DEF_END_CHAR   = 8'h3E;  // '>'
  localparam logic [7:0] DEF_SEP_CHAR   = 8'h2C;  // ','
  localparam logic [7:0] CHAR_MINUS     = 8'h2D;  // '-'

  function automatic logic is_digit(input logic [7:0] b);
    return (b >= 8'h30) && (b <= 8'h39);
  endfunction

endpackage

// File: rtl/ascii_dec_acc.sv
// Signed decimal field accumulator: sign, magnitude with sticky overflow,
// and clamping of the result to the signed WIDTH-bit range.
module ascii_dec_acc #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             set_neg,
  input  logic             digit_valid,
  input  logic [3:0]       digit,
  output logic [WIDTH-1:0] value,
  output logic             sat,
  output logic             has_digit
);

  localparam int MW = WIDTH + 4;
  localparam int EW = WIDTH + 8;

  localparam logic [MW-1:0] POS_LIM = {{(MW - WIDTH + 1){1'b0}}, {(WIDTH - 1){1'b1}}};
  localparam logic [MW-1:0] NEG_LIM = {{(MW - WIDTH){1'b0}}, 1'b1, {(WIDTH - 1){1'b0}}};

  logic          neg_q, neg_d;
  logic [MW-1:0] mag_q, mag_d;
  logic          ovf_q, ovf_d;
  logic          has_digit_q, has_digit_d;
  logic [EW-1:0] next_mag;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can
    // fall through and infer a latch.
    neg_d       = neg_q;
    mag_d       = mag_q;
    ovf_d       = ovf_q;
    has_digit_d = has_digit_q;
    // mag*10 + digit, computed 4 bits wider so the carry-out is visible.
    next_mag    = ({4'b0000, mag_q} << 3) + ({4'b0000, mag_q} << 1) + EW'(digit);
    if (clear) begin
      neg_d       = 1'b0;
      mag_d       = '0;
      ovf_d       = 1'b0;
      has_digit_d = 1'b0;
    end else begin
      if (set_neg) neg_d = 1'b1;
      if (digit_valid) begin
        mag_d       = next_mag[MW-1:0];
        has_digit_d = 1'b1;
        if (next_mag[EW-1:MW] != '0) ovf_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples the pre-edge values of its neighbours.
    if (reset) begin
      neg_q       <= 1'b0;
      mag_q       <= '0;
      ovf_q       <= 1'b0;
      has_digit_q <= 1'b0;
    end else begin
      neg_q       <= neg_d;
      mag_q       <= mag_d;
      ovf_q       <= ovf_d;
      has_digit_q <= has_digit_d;
    end
  end

  always_comb begin
    sat = ovf_q || (neg_q ? (mag_q > NEG_LIM) : (mag_q > POS_LIM));
    if (sat) value = neg_q ? {1'b1, {(WIDTH - 1){1'b0}}} : {1'b0, {(WIDTH - 1){1'b1}}};
    else     value = neg_q ? -mag_q[WIDTH-1:0] : mag_q[WIDTH-1:0];
  end

  assign has_digit = has_digit_q;

endmodule

// File: rtl/camera_frame_parser.sv
// Parses "<v0,v1,...>" ASCII frames from a UART byte stream into a bank of
// signed fields, committing all fields atomically on a well-formed frame.
module camera_frame_parser
  import camera_pkg::*;
#(
  parameter int         NUM_FIELDS = 6,
  parameter int         WIDTH      = 32,
  parameter logic [7:0] START_CHAR = DEF_START_CHAR,
  parameter logic [7:0] END_CHAR   = DEF_END_CHAR,
  parameter logic [7:0] SEP_CHAR   = DEF_SEP_CHAR
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [7:0]                  rx_data,
  input  logic                        rx_valid,
  output logic [NUM_FIELDS*WIDTH-1:0] fields,
  output logic                        frame_done,
  output logic                        frame_error,
  output logic                        sat_flag,
  output logic                        busy
);

  localparam int IDX_W = (NUM_FIELDS > 1) ? $clog2(NUM_FIELDS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_FIELDS - 1);

  state_e                               state_q, state_d;
  logic [IDX_W-1:0]                     idx_q, idx_d;
  logic [NUM_FIELDS-1:0][WIDTH-1:0]     shadow_q, shadow_d;
  logic [NUM_FIELDS-1:0]                shadow_sat_q, shadow_sat_d;
  logic [NUM_FIELDS-1:0][WIDTH-1:0]     fields_q, fields_d;
  logic                                 frame_done_q, frame_done_d;
  logic                                 frame_error_q, frame_error_d;
  logic                                 sat_flag_q, sat_flag_d;

  logic             acc_clear, acc_set_neg, acc_digit_valid;
  logic [WIDTH-1:0] acc_value;
  logic             acc_sat, acc_has_digit;
  logic             abort;

  ascii_dec_acc #(.WIDTH(WIDTH)) u_acc (
    .clk        (clk),
    .reset      (reset),
    .clear      (acc_clear),
    .set_neg    (acc_set_neg),
    .digit_valid(acc_digit_valid),
    .digit      (rx_data[3:0]),
    .value      (acc_value),
    .sat        (acc_sat),
    .has_digit  (acc_has_digit)
  );

  always_comb begin
    state_d         = state_q;
    idx_d           = idx_q;
    shadow_d        = shadow_q;
    shadow_sat_d    = shadow_sat_q;
    fields_d        = fields_q;
    sat_flag_d      = sat_flag_q;
    frame_done_d    = 1'b0;
    frame_error_d   = 1'b0;
    acc_clear       = 1'b0;
    acc_set_neg     = 1'b0;
    acc_digit_valid = 1'b0;
    abort           = 1'b0;

    if (rx_valid) begin
      // A start byte always (re)opens a frame, silently dropping any open one.
      if (rx_data == START_CHAR) begin
        state_d   = SIGN;
        idx_d     = '0;
        acc_clear = 1'b1;
      end else begin
        case (state_q)
          IDLE: ;
          SIGN: begin
            if (rx_data == CHAR_MINUS) begin
              acc_set_neg = 1'b1;
              state_d     = DIGITS;
            end else if (is_digit(rx_data)) begin
              acc_digit_valid = 1'b1;
              state_d         = DIGITS;
            end else begin
              abort = 1'b1;
            end
          end
          DIGITS: begin
            if (is_digit(rx_data)) begin
              acc_digit_valid = 1'b1;
            end else if ((rx_data == SEP_CHAR || rx_data == END_CHAR) && acc_has_digit) begin
              shadow_d[idx_q]     = acc_value;
              shadow_sat_d[idx_q] = acc_sat;
              acc_clear           = 1'b1;
              if (rx_data == SEP_CHAR && idx_q != LAST_IDX) begin
                idx_d   = idx_q + 1'b1;
                state_d = SIGN;
              end else if (rx_data == END_CHAR && idx_q == LAST_IDX) begin
                fields_d     = shadow_d;
                sat_flag_d   = |shadow_sat_d;
                frame_done_d = 1'b1;
                state_d      = IDLE;
              end else begin
                abort = 1'b1;
              end
            end else begin
              abort = 1'b1;
            end
          end
          default: abort = 1'b1;
        endcase
      end
      if (abort) begin
        frame_error_d = 1'b1;
        state_d       = IDLE;
        acc_clear     = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      idx_q         <= '0;
      // NOTE: the shadow bank is a small flop array, not RAM, so it is reset
      // like any other register.
      shadow_q      <= '0;
      shadow_sat_q  <= '0;
      fields_q      <= '0;
      frame_done_q  <= 1'b0;
      frame_error_q <= 1'b0;
      sat_flag_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      shadow_q      <= shadow_d;
      shadow_sat_q  <= shadow_sat_d;
      fields_q      <= fields_d;
      frame_done_q  <= frame_done_d;
      frame_error_q <= frame_error_d;
      sat_flag_q    <= sat_flag_d;
    end
  end

  assign fields      = fields_q;
  assign frame_done  = frame_done_q;
  assign frame_error = frame_error_q;
  assign sat_flag    = sat_flag_q;
  assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_camera_frame_parser.sv
// Bench for camera_frame_parser: directed frames plus random frames, checked
// every cycle against a token-level reference parser.
module tb_camera_frame_parser;

  localparam int NF = 3;
  localparam int W  = 16;

  logic             clk = 1'b0;
  logic             reset;
  logic [7:0]       rx_data;
  logic             rx_valid;
  logic [NF*W-1:0]  fields;
  logic             frame_done, frame_error, sat_flag, busy;

  always #5 clk = ~clk;

  camera_frame_parser #(.NUM_FIELDS(NF), .WIDTH(W)) dut (
    .clk        (clk),
    .reset      (reset),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .fields     (fields),
    .frame_done (frame_done),
    .frame_error(frame_error),
    .sat_flag   (sat_flag),
    .busy       (busy)
  );

  int n_checks = 0;
  int n_errors = 0;
  int n_done   = 0;
  int n_err_p  = 0;

  // Reference parser state: frame text is kept as completed values plus the
  // raw characters of the field currently being typed.
  bit               m_open;
  logic [W-1:0]     m_vals[$];
  bit               m_sats[$];
  byte unsigned     m_tok[$];
  logic [NF*W-1:0]  m_fields;
  bit               m_sat;
  bit               exp_done, exp_err, exp_busy;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_open = 0;
    m_vals.delete();
    m_sats.delete();
    m_tok.delete();
    m_fields = '0;
    m_sat    = 0;
    exp_done = 0;
    exp_err  = 0;
    exp_busy = 0;
  endtask

  task automatic model_abort();
    exp_err = 1;
    m_open  = 0;
    m_vals.delete();
    m_sats.delete();
    m_tok.delete();
  endtask

  function automatic bit tok_has_digit();
    foreach (m_tok[i]) if (m_tok[i] >= "0" && m_tok[i] <= "9") return 1;
    return 0;
  endfunction

  // Decimal text to clamped signed value, using wide integer arithmetic.
  task automatic parse_tok(output logic [W-1:0] v, output bit s);
    longint mag = 0;
    bit     neg = 0;
    foreach (m_tok[i]) begin
      if (m_tok[i] == "-") neg = 1;
      else if (mag < 64'd1_000_000_000) mag = mag * 10 + longint'(m_tok[i] - 8'h30);
    end
    s = 0;
    if (neg) begin
      if (mag > 32768) begin v = 16'h8000; s = 1; end
      else v = W'(-mag);
    end else begin
      if (mag > 32767) begin v = 16'h7FFF; s = 1; end
      else v = W'(mag);
    end
  endtask

  task automatic model_byte(input byte unsigned b);
    logic [W-1:0] v;
    bit           s;
    if (b == "<") begin
      m_open = 1;
      m_vals.delete();
      m_sats.delete();
      m_tok.delete();
    end else if (!m_open) begin
      // bytes between frames are ignored
    end else if (b >= "0" && b <= "9") begin
      m_tok.push_back(b);
    end else if (b == "-") begin
      if (m_tok.size() == 0) m_tok.push_back(b);
      else model_abort();
    end else if (b == "," || b == ">") begin
      if (!tok_has_digit()) model_abort();
      else begin
        parse_tok(v, s);
        m_vals.push_back(v);
        m_sats.push_back(s);
        m_tok.delete();
        if (b == ",") begin
          if (m_vals.size() >= NF) model_abort();
        end else if (m_vals.size() == NF) begin
          m_sat = 0;
          for (int i = 0; i < NF; i++) begin
            m_fields[i*W +: W] = m_vals[i];
            m_sat = m_sat | m_sats[i];
          end
          exp_done = 1;
          m_open   = 0;
        end else begin
          model_abort();
        end
      end
    end else begin
      model_abort();
    end
    exp_busy = m_open;
  endtask

  // One clock: check the results of the previous cycle's input, then drive.
  task automatic cycle(input bit v, input byte unsigned b);
    @(negedge clk);
    check("frame_done", frame_done, exp_done);
    check("frame_error", frame_error, exp_err);
    check("busy", busy, exp_busy);
    check("fields", fields, m_fields);
    check("sat_flag", sat_flag, m_sat);
    if (frame_done === 1'b1) n_done++;
    if (frame_error === 1'b1) n_err_p++;
    rx_valid = v;
    rx_data  = b;
    exp_done = 0;
    exp_err  = 0;
    if (v) model_byte(b);
  endtask

  task automatic send_str(input string s, input int max_gap);
    for (int i = 0; i < s.len(); i++) begin
      cycle(1'b1, s[i]);
      repeat ($urandom_range(0, max_gap)) cycle(1'b0, 8'h00);
    end
    cycle(1'b0, 8'h00);
  endtask

  task automatic do_reset();
    cycle(1'b0, 8'h00);
    #1 reset = 1'b1;
    model_reset();
    #1;
    check("rst_busy", busy, 1'b0);
    check("rst_fields", fields, '0);
    check("rst_done", frame_done, 1'b0);
    check("rst_error", frame_error, 1'b0);
    check("rst_sat", sat_flag, 1'b0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  function automatic string rand_num();
    string s;
    case ($urandom_range(0, 3))
      0:       s = $sformatf("%0d", $urandom_range(0, 999));
      1:       s = $sformatf("%0d", $urandom_range(0, 40000));
      2:       s = $sformatf("%0d%0d", $urandom, $urandom);
      default: s = $sformatf("%0d", $urandom_range(32760, 32775));
    endcase
    if ($urandom_range(0, 1) == 1) s = {"-", s};
    return s;
  endfunction

  initial begin
    int d0, e0, nf, kind;
    string s;

    reset    = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    model_reset();
    #2;
    check("init_busy", busy, 1'b0);
    check("init_fields", fields, '0);
    check("init_done", frame_done, 1'b0);
    check("init_error", frame_error, 1'b0);
    check("init_sat", sat_flag, 1'b0);
    @(negedge clk);
    reset = 1'b0;

    d0 = n_done; e0 = n_err_p;
    send_str("<12,-7,300>", 0);
    check("basic_fields", fields, {16'd300, 16'hFFF9, 16'd12});
    check("basic_sat", sat_flag, 1'b0);
    check("basic_done_cnt", n_done - d0, 1);

    e0 = n_err_p;
    send_str("<1,2>", 0);
    check("short_err_cnt", n_err_p - e0, 1);
    check("short_fields", fields, {16'd300, 16'hFFF9, 16'd12});

    send_str("<99999,-99999,0>", 0);
    check("sat_fields", fields, {16'd0, 16'h8000, 16'h7FFF});
    check("sat_flag_set", sat_flag, 1'b1);

    e0 = n_err_p; d0 = n_done;
    send_str("<5,x,1>", 0);
    send_str("<1,1,1>", 0);
    check("illegal_err_cnt", n_err_p - e0, 1);
    check("illegal_recover", fields, {16'd1, 16'd1, 16'd1});
    check("sat_cleared", sat_flag, 1'b0);
    check("illegal_done_cnt", n_done - d0, 1);

    e0 = n_err_p; d0 = n_done;
    send_str("<4,4<8,9,10>", 0);
    check("restart_fields", fields, {16'd10, 16'd9, 16'd8});
    check("restart_done_cnt", n_done - d0, 1);
    check("restart_err_cnt", n_err_p - e0, 0);

    send_str("<-,1,2>", 0);
    send_str("<,1,2,3>", 1);
    send_str("<1,2,3,4>", 0);
    check("empty_fields_keep", fields, {16'd10, 16'd9, 16'd8});

    send_str("<3,3", 0);
    do_reset();
    send_str("<1,2,3>", 0);
    check("post_reset_fields", fields, {16'd3, 16'd2, 16'd1});

    send_str("<32767,-32768,-0>", 0);
    check("edge_fields", fields, {16'd0, 16'h8000, 16'h7FFF});
    check("edge_sat", sat_flag, 1'b0);

    for (int f = 0; f < 250; f++) begin
      kind = $urandom_range(0, 9);
      nf   = (kind == 0) ? $urandom_range(1, 5) : NF;
      s    = (kind == 2) ? "zz9-," : "";
      s    = {s, "<"};
      for (int i = 0; i < nf; i++) begin
        if (i > 0) s = {s, ","};
        s = {s, rand_num()};
      end
      s = {s, ">"};
      if (kind == 1) s.putc($urandom_range(1, s.len() - 1), byte'($urandom_range(33, 126)));
      send_str(s, (kind == 3) ? 2 : 0);
      if (kind == 4 && $urandom_range(0, 3) == 0) begin
        send_str("<7,", 0);
        do_reset();
      end
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
